rv_regs_wb: RTL and testbench

//  Write-side front end of the integer register file. Merges the in-order ALU/CSR

---
 rtl/rv_pkg.sv | 15 +
 rtl/rv_wb_fifo.sv | 56 +++++
 rtl/rv_regs_wb.sv | 118 +++++++++++
 tb/tb_rv_regs_wb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types for the register-file write-back front end.
package rv_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   localparam logic [4:0] REG_ZERO = '0;

   function automatic logic rd_writes(input logic [4:0] rd);
      return rd != REG_ZERO;
   endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// Late-result (B) queue: pointer FIFO with a per-entry live bit that a younger
// A write to the same rd can clear; dead entries still pop in order.
module rv_wb_fifo
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  wb_req_t push_req,
   input  logic    pop,
   input  logic    kill,
   input  logic [4:0] kill_rd,
   output wb_req_t head_req,
   output logic    head_live,
   output logic    empty,
   output logic    full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [DEPTH-1:0] live;
   wb_req_t          mem [DEPTH];

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_req  = mem[rd_ptr[AW-1:0]];
   assign head_live = live[rd_ptr[AW-1:0]];

   // Killing free slots is harmless; the push below re-arms the slot it fills.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         live   <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill && (mem[i[AW-1:0]].rd == kill_rd)) live[i[AW-1:0]] <= 1'b0;
         end
         if (push) begin
            live[wr_ptr[AW-1:0]] <= 1'b1;
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_req;
   end

endmodule

// File: rtl/rv_regs_wb.sv
// Register-file write-port merge of the A (ALU/CSR) and B (LSU/MUL) result streams.
// Optional read bypass of same-edge commits is enabled by defining RV_WB_BYPASS_EN.
module rv_regs_wb
   import rv_pkg::*;
#(
   parameter int unsigned B_DEPTH      = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_a_valid,
   input  logic [4:0]  i_a_rd,
   input  logic [31:0] i_a_data,
   output logic        o_a_stall,
   input  logic        i_b_valid,
   output logic        o_b_ready,
   input  logic [4:0]  i_b_rd,
   input  logic [31:0] i_b_data,
   output logic [4:0]  o_rd,
   output logic        o_write,
   output logic [31:0] o_data,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_rf_data1,
   input  logic [31:0] i_rf_data2,
   output logic [31:0] o_data1,
   output logic [31:0] o_data2
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   logic    a_win, b_pop, b_push;
   logic    q_empty, q_full, head_live;
   wb_req_t head_req;
   logic [CW-1:0] starve_cnt, starve_nxt;

   assign a_win     = i_a_valid && rd_writes(i_a_rd);
   assign b_pop     = !a_win && !q_empty;
   assign o_b_ready = !q_full || b_pop;
   assign b_push    = i_b_valid && o_b_ready && rd_writes(i_b_rd);

   rv_wb_fifo #(.DEPTH(B_DEPTH)) u_b_fifo (
      .clk       (i_clk),
      .rst_n     (i_reset_n),
      .push      (b_push),
      .push_req  ('{rd: i_b_rd, data: i_b_data}),
      .pop       (b_pop),
      .kill      (a_win),
      .kill_rd   (i_a_rd),
      .head_req  (head_req),
      .head_live (head_live),
      .empty     (q_empty),
      .full      (q_full)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_write <= 1'b0;
         o_rd    <= '0;
         o_data  <= '0;
      end else if (a_win) begin
         o_write <= 1'b1;
         o_rd    <= i_a_rd;
         o_data  <= i_a_data;
      end else if (b_pop) begin
         o_write <= head_live;
         o_rd    <= head_req.rd;
         o_data  <= head_req.data;
      end else begin
         o_write <= 1'b0;
      end
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (b_pop) starve_nxt = '0;
      else if (q_full && a_win && (starve_cnt != STARVE_MAX)) starve_nxt = starve_cnt + CNT_ONE;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         starve_cnt <= '0;
         o_a_stall  <= 1'b0;
      end else begin
         starve_cnt <= starve_nxt;
         o_a_stall  <= (starve_nxt == STARVE_MAX);
      end
   end

`ifdef RV_WB_BYPASS_EN
   logic        hit1, hit2;
   logic [31:0] byp_data;

   // o_rd is never x0 while o_write is high, so rs==0 cannot hit.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hit1     <= 1'b0;
         hit2     <= 1'b0;
         byp_data <= '0;
      end else begin
         hit1     <= o_write && (o_rd == i_rs1);
         hit2     <= o_write && (o_rd == i_rs2);
         byp_data <= o_data;
      end
   end

   assign o_data1 = hit1 ? byp_data : i_rf_data1;
   assign o_data2 = hit2 ? byp_data : i_rf_data2;
`else
   logic unused_rs;
   assign unused_rs = ^{i_rs1, i_rs2};
   assign o_data1   = i_rf_data1;
   assign o_data2   = i_rf_data2;
`endif

endmodule

// File: tb/tb_rv_regs_wb.sv
// Bench for rv_regs_wb: directed vector table, hand sequences, and a queue-based
// reference model under random traffic; honours RV_WB_BYPASS_EN like the design.
module tb_rv_regs_wb;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0]  a_rd = '0, b_rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        a_stall, b_ready, wr;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data, rf_q1, rf_q2, data1, data2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rv_regs_wb #(.B_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_a_valid  (a_valid),
      .i_a_rd     (a_rd),
      .i_a_data   (a_data),
      .o_a_stall  (a_stall),
      .i_b_valid  (b_valid),
      .o_b_ready  (b_ready),
      .i_b_rd     (b_rd),
      .i_b_data   (b_data),
      .o_rd       (wr_rd),
      .o_write    (wr),
      .o_data     (wr_data),
      .i_rs1      (rs1),
      .i_rs2      (rs2),
      .i_rf_data1 (rf_q1),
      .i_rf_data2 (rf_q2),
      .o_data1    (data1),
      .o_data2    (data2)
   );

   // Environment register file: registered read, commits the DUT write port.
   logic        rf_clr = 1'b1;
   logic [31:0] rf [32];
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wr) begin
         rf[wr_rd] <= wr_data;
      end
      rf_q1 <= (rs1 == 5'd0) ? 32'd0 : rf[rs1];
      rf_q2 <= (rs2 == 5'd0) ? 32'd0 : rf[rs2];
   end

   // Expected architectural register state and the write awaiting commit.
   logic [31:0] shadow [32];
   logic        pend_w = 1'b0;
   logic [4:0]  pend_rd = '0;
   logic [31:0] pend_d = '0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          live;
   } mentry_t;
   mentry_t mq [$];
   int      mcnt = 0;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  brd;
      logic [31:0] bd;
      logic        erdy;
      logic        ew;
      logic [4:0]  erd;
      logic [31:0] ed;
      logic        es;
   } vec_t;
   vec_t tbl [26];

   function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                               logic bv, logic [4:0] brd, logic [31:0] bd,
                               logic erdy, logic ew, logic [4:0] erd,
                               logic [31:0] ed, logic es);
      vec_t v;
      v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
      v.erdy = erdy; v.ew = ew; v.erd = erd; v.ed = ed; v.es = es;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check the combinational ready, then the registered results.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic erdy, input logic ew, input logic [4:0] erd,
                       input logic [31:0] ed, input logic es, input string tag);
      logic [31:0] pre1, pre2, post1, post2;
      a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      rs1 = r1; rs2 = r2;
      #2;
      chk({tag, ".ready"}, {31'd0, b_ready}, {31'd0, erdy});
      @(posedge clk);
      #1;
      pre1 = (r1 == 5'd0) ? 32'd0 : shadow[r1];
      pre2 = (r2 == 5'd0) ? 32'd0 : shadow[r2];
      if (pend_w) shadow[pend_rd] = pend_d;
      post1 = (r1 == 5'd0) ? 32'd0 : shadow[r1];
      post2 = (r2 == 5'd0) ? 32'd0 : shadow[r2];
      chk({tag, ".write"}, {31'd0, wr}, {31'd0, ew});
      if (ew) begin
         chk({tag, ".rd"}, {27'd0, wr_rd}, {27'd0, erd});
         chk({tag, ".data"}, wr_data, ed);
      end
      chk({tag, ".stall"}, {31'd0, a_stall}, {31'd0, es});
`ifdef RV_WB_BYPASS_EN
      chk({tag, ".data1"}, data1, post1);
      chk({tag, ".data2"}, data2, post2);
`else
      chk({tag, ".data1"}, data1, pre1);
      chk({tag, ".data2"}, data2, pre2);
`endif
      pend_w = ew; pend_rd = erd; pend_d = ed;
   endtask

   task automatic idle(input logic ew, input logic [4:0] erd, input logic [31:0] ed, input string tag);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, ew, erd, ed, 0, tag);
   endtask

   // Mid-run reset: outputs drop immediately and the pending write never commits.
   task automatic pulse_reset(input string tag);
      a_valid = 0; b_valid = 0; rs1 = 0; rs2 = 0;
      rst_n = 1'b0;
      #1;
      chk({tag, ".write"}, {31'd0, wr}, 32'd0);
      chk({tag, ".ready"}, {31'd0, b_ready}, 32'd1);
      chk({tag, ".stall"}, {31'd0, a_stall}, 32'd0);
      mq.delete();
      mcnt = 0;
      pend_w = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Reference: B results wait in arrival order; an A write retires every older
   // queued result for the same register; a full queue losing to A accrues starvation.
   task automatic model_cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                              output logic erdy, output logic ew, output logic [4:0] erd,
                              output logic [31:0] ed, output logic es);
      bit      a_takes, b_leaves, was_full;
      mentry_t e;
      a_takes  = av && (ard != 5'd0);
      b_leaves = !a_takes && (mq.size() != 0);
      was_full = (mq.size() == DEPTH);
      erdy = !was_full || b_leaves;
      ew = 1'b0; erd = '0; ed = '0;
      if (a_takes) begin
         ew = 1'b1; erd = ard; ed = ad;
         foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      end else if (b_leaves) begin
         e = mq.pop_front();
         ew = e.live; erd = e.rd; ed = e.data;
      end
      if (bv && erdy && (brd != 5'd0)) mq.push_back('{rd: brd, data: bd, live: 1'b1});
      if (b_leaves) mcnt = 0;
      else if (was_full && a_takes && mcnt < int'(LIMIT)) mcnt++;
      es = (mcnt == int'(LIMIT));
   endtask

   initial begin
      logic        av, bv, erdy, ew, es;
      logic [4:0]  ard, brd, erd, r1, r2;
      logic [31:0] ad, bd, ed;
      int          pa;

      for (int i = 0; i < 32; i++) shadow[i] = '0;

      tbl[0]  = mk(1, 5,  32'h11,  0, 0, 0,       1, 1, 5,  32'h11,  0);
      tbl[1]  = mk(0, 0,  0,       1, 3, 32'h22,  1, 0, 0,  0,       0);
      tbl[2]  = mk(1, 0,  32'hFF,  0, 0, 0,       1, 1, 3,  32'h22,  0);
      tbl[3]  = mk(1, 10, 32'h100, 1, 7, 32'hAA,  1, 1, 10, 32'h100, 0);
      tbl[4]  = mk(1, 11, 32'h101, 1, 7, 32'hBB,  1, 1, 11, 32'h101, 0);
      tbl[5]  = mk(1, 12, 32'h102, 0, 0, 0,       0, 1, 12, 32'h102, 0);
      tbl[6]  = mk(1, 13, 32'h103, 0, 0, 0,       0, 1, 13, 32'h103, 0);
      tbl[7]  = mk(1, 14, 32'h104, 0, 0, 0,       0, 1, 14, 32'h104, 0);
      tbl[8]  = mk(1, 15, 32'h105, 0, 0, 0,       0, 1, 15, 32'h105, 1);
      tbl[9]  = mk(0, 0,  0,       0, 0, 0,       1, 1, 7,  32'hAA,  0);
      tbl[10] = mk(0, 0,  0,       0, 0, 0,       1, 1, 7,  32'hBB,  0);
      tbl[11] = mk(0, 0,  0,       0, 0, 0,       1, 0, 0,  0,       0);
      tbl[12] = mk(0, 0,  0,       1, 9, 32'h1,   1, 0, 0,  0,       0);
      tbl[13] = mk(1, 9,  32'h2,   0, 0, 0,       1, 1, 9,  32'h2,   0);
      tbl[14] = mk(0, 0,  0,       0, 0, 0,       1, 0, 0,  0,       0);
      tbl[15] = mk(0, 0,  0,       0, 0, 0,       1, 0, 0,  0,       0);
      tbl[16] = mk(0, 0,  0,       1, 0, 32'h33,  1, 0, 0,  0,       0);
      tbl[17] = mk(0, 0,  0,       0, 0, 0,       1, 0, 0,  0,       0);
      tbl[18] = mk(1, 6,  32'h44,  1, 6, 32'h45,  1, 1, 6,  32'h44,  0);
      tbl[19] = mk(0, 0,  0,       0, 0, 0,       1, 1, 6,  32'h45,  0);
      tbl[20] = mk(0, 0,  0,       1, 1, 32'h50,  1, 0, 0,  0,       0);
      tbl[21] = mk(1, 2,  32'h60,  1, 1, 32'h51,  1, 1, 2,  32'h60,  0);
      tbl[22] = mk(0, 0,  0,       1, 1, 32'h52,  1, 1, 1,  32'h50,  0);
      tbl[23] = mk(0, 0,  0,       0, 0, 0,       1, 1, 1,  32'h51,  0);
      tbl[24] = mk(0, 0,  0,       0, 0, 0,       1, 1, 1,  32'h52,  0);
      tbl[25] = mk(0, 0,  0,       0, 0, 0,       1, 0, 0,  0,       0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rf_clr = 1'b0;
      @(posedge clk);
      #1;
      chk("reset.write", {31'd0, wr}, 32'd0);
      chk("reset.rd", {27'd0, wr_rd}, 32'd0);
      chk("reset.data", wr_data, 32'd0);
      chk("reset.stall", {31'd0, a_stall}, 32'd0);
      chk("reset.ready", {31'd0, b_ready}, 32'd1);
      chk("reset.data1", data1, 32'd0);

      for (int i = 0; i < 26; i++) begin
         step(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].bv, tbl[i].brd, tbl[i].bd, 0, 0,
              tbl[i].erdy, tbl[i].ew, tbl[i].erd, tbl[i].ed, tbl[i].es, $sformatf("vec%0d", i));
      end

      // Write to x4 commits on the same edge that samples rs1/rs2=4.
      step(1, 4, 32'h55, 0, 0, 0, 0, 0, 1, 1, 4, 32'h55, 0, "byp.issue");
      step(0, 0, 0, 0, 0, 0, 4, 4, 1, 0, 0, 0, 0, "byp.hazard");
      step(0, 0, 0, 0, 0, 0, 4, 4, 1, 0, 0, 0, 0, "byp.settled");

      // Reset with two B results queued: nothing of them may reach the port.
      step(1, 20, 32'h70, 1, 21, 32'h71, 0, 0, 1, 1, 20, 32'h70, 0, "rst.fill0");
      step(1, 22, 32'h72, 1, 23, 32'h73, 0, 0, 1, 1, 22, 32'h72, 0, "rst.fill1");
      pulse_reset("rst.mid");
      idle(0, 0, 0, "rst.after0");
      idle(0, 0, 0, "rst.after1");
      idle(0, 0, 0, "rst.after2");

      pulse_reset("rnd.start");
      for (int i = 0; i < 600; i++) begin
         case (i / 100)
            0: pa = 30;
            1: pa = 92;
            2: pa = 55;
            3: pa = 97;
            4: pa = 10;
            default: pa = 70;
         endcase
         if (i == 350) pulse_reset("rnd.reset");
         av  = ($urandom_range(0, 99) < pa);
         ard = 5'($urandom_range(0, 7));
         ad  = $urandom;
         bv  = ($urandom_range(0, 99) < 70);
         brd = 5'($urandom_range(0, 7));
         bd  = $urandom;
         r1  = 5'($urandom_range(0, 7));
         r2  = 5'($urandom_range(0, 7));
         model_cycle(av, ard, ad, bv, brd, bd, erdy, ew, erd, ed, es);
         step(av, ard, ad, bv, brd, bd, r1, r2, erdy, ew, erd, ed, es, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
